// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-port memory responder.
package data_mem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    // Data RAM base address, shared with processor test programs
    localparam logic [ADDR_W-1:0] DATA_BASE_ADDR = 32'h1001_0000;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core data port and the memory responder.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// Word storage with synchronous byte-lane writes and combinational read.
module mem_word_array
    import data_mem_responder_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) mem[idx_i] <= be_merge(mem[idx_i], wdata_i, be_i);
    end

    assign rdata_c = mem[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data RAM responder: one outstanding request, registered response.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DATA_BASE_ADDR,
    parameter int unsigned       WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Zero wait states still needs one cycle to read the captured request
    localparam logic [CNT_W-1:0] LOAD_CNT =
        (WAIT_CYCLES == 0) ? CNT_W'(1) : CNT_W'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [ADDR_W-1:0] off_c;
    logic              err_c;
    logic              mem_we_c;
    logic [DATA_W-1:0] mem_rdata_c;

    // Address decode on the captured request; 32-bit wrap keeps low addresses out of range
    assign off_c = req_q.addr - BASE_ADDR;
    assign err_c = (req_q.addr[1:0] != 2'b00) || (req_q.addr < BASE_ADDR) ||
                   ((off_c >> 2) >= ADDR_W'(DEPTH_WORDS));

    mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk     (clk),
        .we_i    (mem_we_c),
        .be_i    (req_q.be),
        .idx_i   (off_c[IDX_W+1:2]),
        .wdata_i (req_q.wdata),
        .rdata_c (mem_rdata_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_we_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    req_d   = '{we: bus.req_we, addr: bus.req_addr,
                                wdata: bus.req_wdata, be: bus.req_be};
                    cnt_d   = LOAD_CNT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Access edge: storage update or read capture, response goes valid
                if (cnt_q <= CNT_W'(1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_c;
                    rsp_rdata_d = '0;
                    if (!err_c) begin
                        if (req_q.we) mem_we_c    = 1'b1;
                        else          rsp_rdata_d = mem_rdata_c;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: two builds (2 and 0 wait states).
module tb_data_mem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_v, req_we_v, rsp_ready_v;
    logic [31:0] req_addr_v, req_wdata_v;
    logic [3:0]  req_be_v;
    int          sel;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    data_mem_responder_if b2 ();
    data_mem_responder_if b0 ();

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1001_0000), .WAIT_CYCLES(2))
        dut (.clk(clk), .reset(reset), .bus(b2.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1001_0000), .WAIT_CYCLES(0))
        dut0 (.clk(clk), .reset(reset), .bus(b0.slave));

    assign b2.req_valid = req_valid_v && (sel == 0);
    assign b0.req_valid = req_valid_v && (sel == 1);
    assign b2.req_we    = req_we_v;    assign b0.req_we    = req_we_v;
    assign b2.req_addr  = req_addr_v;  assign b0.req_addr  = req_addr_v;
    assign b2.req_wdata = req_wdata_v; assign b0.req_wdata = req_wdata_v;
    assign b2.req_be    = req_be_v;    assign b0.req_be    = req_be_v;
    assign b2.rsp_ready = rsp_ready_v; assign b0.rsp_ready = rsp_ready_v;

    wire        ready_m     = (sel == 1) ? b0.req_ready : b2.req_ready;
    wire        rsp_valid_m = (sel == 1) ? b0.rsp_valid : b2.rsp_valid;
    wire [31:0] rsp_rdata_m = (sel == 1) ? b0.rsp_rdata : b2.rsp_rdata;
    wire        rsp_err_m   = (sel == 1) ? b0.rsp_err   : b2.rsp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is checked against the oldest expectation
    always @(negedge clk) begin
        if (!reset && rsp_valid_m && rsp_ready_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp act=%h exp=none", rsp_rdata_m);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata_m, e.rdata);
                check("rsp_err", 32'(rsp_err_m), 32'(e.err));
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat);
        int n;
        int lat;
        @(posedge clk); #1;
        req_we_v = we; req_addr_v = addr; req_wdata_v = wdata; req_be_v = be;
        req_valid_v = 1'b1;
        n = 0;
        while (!ready_m && n < 20) begin @(posedge clk); #1; n++; end
        check("req_ready_wait", 32'(ready_m), 32'd1);
        @(posedge clk);
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        #1 req_valid_v = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!rsp_valid_m && lat < 20);
        check("latency", 32'(lat), 32'(exp_lat));
        n = 0;
        while (rsp_valid_m && n < 20) begin @(posedge clk); #1; n++; end
        check("rsp_cleared", 32'(rsp_valid_m), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; sel = 0;
        req_valid_v = 1'b0; req_we_v = 1'b0; req_addr_v = '0; req_wdata_v = '0;
        req_be_v = '0; rsp_ready_v = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_req_ready", 32'(b2.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        check("rst_rsp_rdata", b2.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(b2.rsp_err), 32'd0);
        check("rst0_req_ready", 32'(b0.req_ready), 32'd1);

        // Write then read back
        do_req(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 2);
        do_req(1'b0, 32'h1001_0004, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 2);

        // Partial byte lanes
        do_req(1'b1, 32'h1001_0004, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 2);
        do_req(1'b0, 32'h1001_0004, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, 2);

        // Zero byte enables change nothing
        do_req(1'b1, 32'h1001_0004, 32'h0000_0000, 4'b0000, 32'h0, 1'b0, 2);
        do_req(1'b0, 32'h1001_0004, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, 2);

        // Error accesses leave word 0 untouched
        do_req(1'b1, 32'h1001_0000, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 2);
        do_req(1'b0, 32'h1001_0002, 32'h0, 4'hF, 32'h0, 1'b1, 2);
        do_req(1'b0, 32'h1001_1000, 32'h0, 4'hF, 32'h0, 1'b1, 2);
        do_req(1'b1, 32'h1000_FFFC, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 2);
        do_req(1'b1, 32'h1001_0002, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 2);
        do_req(1'b0, 32'h1001_0FFC, 32'h0, 4'hF, 32'hxxxx_xxxx, 1'b0, 2);
        exp_q.delete();
        do_req(1'b0, 32'h1001_0000, 32'h0, 4'hF, 32'hA5A5_A5A5, 1'b0, 2);

        // Response backpressure with a competing request
        @(posedge clk); #1;
        rsp_ready_v = 1'b0;
        req_we_v = 1'b0; req_addr_v = 32'h1001_0004; req_be_v = 4'hF; req_valid_v = 1'b1;
        check("bp_ready_idle", 32'(ready_m), 32'd1);
        @(posedge clk);
        exp_q.push_back('{rdata: 32'hDE22_BE44, err: 1'b0});
        #1 req_addr_v = 32'h1001_0000;
        n = 0;
        while (!rsp_valid_m && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            req_valid_v = i[0];
            check("bp_rsp_valid", 32'(rsp_valid_m), 32'd1);
            check("bp_rsp_rdata", rsp_rdata_m, 32'hDE22_BE44);
            check("bp_req_ready", 32'(ready_m), 32'd0);
            @(posedge clk); #1;
        end
        req_valid_v = 1'b1;
        exp_q.push_back('{rdata: 32'hA5A5_A5A5, err: 1'b0});
        rsp_ready_v = 1'b1;
        @(posedge clk); #1;
        check("bp_after_hs_ready", 32'(ready_m), 32'd1);
        check("bp_after_hs_valid", 32'(rsp_valid_m), 32'd0);
        @(posedge clk); #1;
        check("bp_accepted", 32'(ready_m), 32'd0);
        req_valid_v = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!rsp_valid_m && n < 20);
        check("bp_latency", 32'(n), 32'd2);
        n = 0;
        while (rsp_valid_m && n < 20) begin @(posedge clk); #1; n++; end

        // Zero-wait build
        sel = 1;
        do_req(1'b1, 32'h1001_0010, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1);
        do_req(1'b0, 32'h1001_0010, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1);
        do_req(1'b0, 32'h1001_0011, 32'h0, 4'hF, 32'h0, 1'b1, 1);
        sel = 0;

        // Reset during ACCESS aborts a pending write
        do_req(1'b1, 32'h1001_0008, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 2);
        @(posedge clk); #1;
        req_we_v = 1'b1; req_addr_v = 32'h1001_0008; req_wdata_v = 32'hFFFF_FFFF;
        req_be_v = 4'hF; req_valid_v = 1'b1;
        check("abort_ready", 32'(ready_m), 32'd1);
        @(posedge clk); #1;
        req_valid_v = 1'b0;
        @(posedge clk); #1;
        check("abort_in_access", 32'(ready_m), 32'd0);
        reset = 1'b1;
        #1;
        check("abort_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        check("abort_req_ready", 32'(b2.req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_req(1'b0, 32'h1001_0008, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 2);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

●
